// File: rtl/fb_pkg.sv
// Shared constants and types for the OLED framebuffer arbiter.
package fb_pkg;
    localparam int FB_ADDR_W = 10;
    localparam int FB_DATA_W = 8;
    localparam int FB_DEPTH  = 1024;
    localparam logic [FB_DATA_W-1:0] FB_CLR_BYTE = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        RD_ISSUED,
        RD_WAIT
    } fb_state_t;
endpackage

// File: rtl/fb_arbiter_if.sv
// Bundle of display, writer, clear and RAM-port signals around the framebuffer arbiter.
interface fb_arbiter_if #(
    parameter int ADDR_W = fb_pkg::FB_ADDR_W,
    parameter int DATA_W = fb_pkg::FB_DATA_W
);
    logic [ADDR_W-1:0] pixel_address;
    logic [DATA_W-1:0] pixel_data;
    logic              frame_start;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clr_start;
    logic              clr_busy;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Master: screen driver, drawing engine and RAM seen from outside the arbiter.
    modport master (
        output pixel_address, wr_valid, wr_addr, wr_data, clr_start, ram_rdata,
        input  pixel_data, frame_start, wr_ready, clr_busy,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  pixel_address, wr_valid, wr_addr, wr_data, clr_start, ram_rdata,
        output pixel_data, frame_start, wr_ready, clr_busy,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/fb_clear_seq.sv
// Zero-fill pointer for the framebuffer: starts at address 0, advances on each
// granted clear write and drops busy when the last address has been issued.
module fb_clear_seq
    import fb_pkg::*;
#(
    parameter int ADDR_W   = FB_ADDR_W,
    parameter int FB_DEPTH = fb_pkg::FB_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              advance,
    output logic [ADDR_W-1:0] ptr,
    output logic              busy
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            ptr  <= '0;
        end else if (!busy) begin
            if (start) begin
                busy <= 1'b1;
                ptr  <= '0;
            end
        end else if (advance) begin
            if (ptr == LAST_ADDR) begin
                busy <= 1'b0;
                ptr  <= '0;
            end else begin
                ptr <= ptr + ADDR_W'(1);
            end
        end
    end
endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer scheduler: display refresh > clear fill > drawing writer.
//   state     | meaning
//   IDLE      | arbitrate one RAM access per cycle
//   RD_ISSUED | display read registered onto the RAM port
//   RD_WAIT   | RAM output valid, captured into pixel_data at the next edge
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W   = FB_ADDR_W,
    parameter int DATA_W   = FB_DATA_W,
    parameter int FB_DEPTH = fb_pkg::FB_DEPTH
) (
    input  logic        clk,
    input  logic        rst_btn,
    fb_arbiter_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    fb_state_t         state, state_nxt;
    logic [ADDR_W-1:0] disp_addr_q;
    logic              disp_pending;
    logic [ADDR_W-1:0] clr_ptr;
    logic              clr_busy;
    logic              grant_disp;
    logic              grant_clr;
    logic              ram_en_q, ram_en_nxt;
    logic              ram_we_q, ram_we_nxt;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_nxt;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_nxt;
    logic [DATA_W-1:0] pixel_data_q;
    logic              frame_start_q;

    fb_clear_seq #(
        .ADDR_W  (ADDR_W),
        .FB_DEPTH(FB_DEPTH)
    ) u_clear (
        .clk    (clk),
        .rst    (rst_btn),
        .start  (bus.clr_start),
        .advance(grant_clr),
        .ptr    (clr_ptr),
        .busy   (clr_busy)
    );

    // Register-only term so the writer never sees a combinational path from its own valid.
    assign bus.wr_ready    = (state == IDLE) && !disp_pending && !clr_busy;
    assign bus.clr_busy    = clr_busy;
    assign bus.ram_en      = ram_en_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.pixel_data  = pixel_data_q;
    assign bus.frame_start = frame_start_q;

    always_comb begin
        state_nxt     = state;
        grant_disp    = 1'b0;
        grant_clr     = 1'b0;
        ram_en_nxt    = 1'b0;
        ram_we_nxt    = 1'b0;
        ram_addr_nxt  = ram_addr_q;
        ram_wdata_nxt = ram_wdata_q;
        case (state)
            IDLE: begin
                if (disp_pending) begin
                    grant_disp   = 1'b1;
                    ram_en_nxt   = 1'b1;
                    ram_addr_nxt = disp_addr_q;
                    state_nxt    = RD_ISSUED;
                end else if (clr_busy) begin
                    grant_clr     = 1'b1;
                    ram_en_nxt    = 1'b1;
                    ram_we_nxt    = 1'b1;
                    ram_addr_nxt  = clr_ptr;
                    ram_wdata_nxt = DATA_W'(FB_CLR_BYTE);
                end else if (bus.wr_valid) begin
                    ram_en_nxt    = 1'b1;
                    ram_we_nxt    = 1'b1;
                    ram_addr_nxt  = bus.wr_addr;
                    ram_wdata_nxt = bus.wr_data;
                end
            end
            RD_ISSUED: state_nxt = RD_WAIT;
            RD_WAIT:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_btn) begin
            state         <= IDLE;
            disp_addr_q   <= '0;
            disp_pending  <= 1'b1;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            pixel_data_q  <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state         <= state_nxt;
            disp_addr_q   <= bus.pixel_address;
            ram_en_q      <= ram_en_nxt;
            ram_we_q      <= ram_we_nxt;
            ram_addr_q    <= ram_addr_nxt;
            ram_wdata_q   <= ram_wdata_nxt;
            frame_start_q <= (disp_addr_q == LAST_ADDR) && (bus.pixel_address == '0);
            // A new address arriving while a read is granted must not be lost.
            if (bus.pixel_address != disp_addr_q) begin
                disp_pending <= 1'b1;
            end else if (grant_disp) begin
                disp_pending <= 1'b0;
            end
            if (state == RD_WAIT) begin
                pixel_data_q <= bus.ram_rdata;
            end
        end
    end
endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: RAM model plus in-order scoreboards of
// expected RAM writes and display reads.
module tb_fb_arbiter;
    import fb_pkg::*;

    logic clk;
    logic rst_btn;

    fb_arbiter_if bus ();

    fb_arbiter dut (
        .clk    (clk),
        .rst_btn(rst_btn),
        .bus    (bus)
    );

    int n_assert  = 0;
    int n_fail    = 0;
    int frame_cnt = 0;
    int burst_cyc;
    int burst_stall;
    int nw;

    logic [7:0]  mem [0:FB_DEPTH-1];
    logic [17:0] wr_q [$];
    logic [9:0]  rd_q [$];
    logic [10:0] log_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 37) + 8'hA5;
    endfunction

    function automatic logic [31:0] ev(input logic we, input logic [9:0] a);
        return {21'd0, we, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input logic [9:0] a);
        bus.pixel_address = a;
        rd_q.push_back(a);
    endtask

    // Synchronous-read single-port RAM.
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata     <= mem[bus.ram_addr];
        end
    end

    always @(negedge clk) begin
        if (bus.frame_start) frame_cnt++;
        if (bus.ram_en) begin
            log_q.push_back({bus.ram_we, bus.ram_addr});
            if (bus.ram_we) begin
                if (wr_q.size() == 0) begin
                    check("wr_extra", wr_q.size(), 1);
                end else begin
                    logic [17:0] e;
                    e = wr_q.pop_front();
                    check("wr_addr", bus.ram_addr, e[17:8]);
                    check("wr_data", bus.ram_wdata, e[7:0]);
                end
            end else begin
                if (rd_q.size() == 0) begin
                    check("rd_extra", rd_q.size(), 1);
                end else begin
                    logic [9:0] a;
                    a = rd_q.pop_front();
                    check("rd_addr", bus.ram_addr, a);
                end
            end
        end
    end

    // Streams n writes; optionally moves the display address while driving item chg_at.
    task automatic write_burst(input int n, input logic [9:0] base, input logic [7:0] dbase,
                               input int chg_at, input logic [9:0] chg_addr,
                               output int cycles, output int stalls);
        cycles = 0;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = base + 10'(i);
            bus.wr_data  = dbase + 8'(i * 3);
            if (i == chg_at) set_pix(chg_addr);
            while (!bus.wr_ready && stalls < 100) begin
                tick();
                stalls++;
                cycles++;
            end
            if (!bus.wr_ready) begin
                check("wr_ready_timeout", bus.wr_ready, 1);
                break;
            end
            wr_q.push_back({bus.wr_addr, bus.wr_data});
            tick();
            cycles++;
        end
        bus.wr_valid = 1'b0;
    endtask

    task automatic run_clear(input bit with_reads);
        bit done = 1'b0;
        bus.clr_start = 1'b1;
        for (int i = 0; i < FB_DEPTH; i++) wr_q.push_back({10'(i), FB_CLR_BYTE});
        tick();
        bus.clr_start = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            if (with_reads) begin
                if (c == 100) set_pix(10'd5);
                if (c == 350) set_pix(10'd600);
                if (c == 600) set_pix(10'd1000);
                if (c == 850) set_pix(10'd3);
                bus.clr_start = (c == 500);
            end
            tick();
            if (!bus.clr_busy) begin
                done = 1'b1;
                check("clr_last_addr", bus.ram_addr, 1023);
                check("clr_last_we", bus.ram_we, 1);
            end
        end
        check("clr_finished", done, 1);
        tick();
        tick();
        check("clr_wr_left", wr_q.size(), 0);
        check("clr_rd_left", rd_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < FB_DEPTH; i++) mem[i] = pat(i);
        rst_btn           = 1'b1;
        bus.pixel_address = '0;
        bus.wr_valid      = 1'b0;
        bus.wr_addr       = '0;
        bus.wr_data       = '0;
        bus.clr_start     = 1'b0;
        repeat (3) tick();

        check("rst_pixel_data", bus.pixel_data, 0);
        check("rst_frame_start", bus.frame_start, 0);
        check("rst_clr_busy", bus.clr_busy, 0);
        check("rst_ram_en", bus.ram_en, 0);
        check("rst_ram_we", bus.ram_we, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_ram_wdata", bus.ram_wdata, 0);
        check("rst_wr_ready", bus.wr_ready, 0);

        // Prefetch of byte 0 lands three edges after the first IDLE cycle.
        rd_q.push_back(10'd0);
        rst_btn = 1'b0;
        check("pf_ready_c0", bus.wr_ready, 0);
        tick();
        check("pf_ready_c1", bus.wr_ready, 0);
        check("pf_pixel_c1", bus.pixel_data, 0);
        tick();
        check("pf_ready_c2", bus.wr_ready, 0);
        check("pf_pixel_c2", bus.pixel_data, 0);
        tick();
        check("pf_pixel_c3", bus.pixel_data, 8'hA5);
        check("pf_ready_c3", bus.wr_ready, 1);

        log_q.delete();
        write_burst(8, 10'h010, 8'h30, -1, 10'd0, burst_cyc, burst_stall);
        check("tp_stalls", burst_stall, 0);
        check("tp_cycles", burst_cyc, 8);
        tick();
        tick();
        check("tp_log_len", log_q.size(), 8);

        // Stall = pending cycle + RD_ISSUED + RD_WAIT.
        log_q.delete();
        write_burst(8, 10'h020, 8'h80, 2, 10'h200, burst_cyc, burst_stall);
        check("pr_stalls", burst_stall, 3);
        check("pr_cycles", burst_cyc, 11);
        tick();
        tick();
        check("pr_log_len", log_q.size(), 9);
        if (log_q.size() == 9) begin
            check("pr_before_rd", log_q[2], ev(1'b1, 10'h022));
            check("pr_rd_first", log_q[3], ev(1'b0, 10'h200));
            check("pr_after_rd", log_q[4], ev(1'b1, 10'h023));
        end
        check("pr_pixel", bus.pixel_data, pat(10'h200));

        set_pix(10'd1022);
        repeat (6) tick();
        check("wr_px_1022", bus.pixel_data, pat(1022));
        set_pix(10'd1023);
        repeat (6) tick();
        check("wr_px_1023", bus.pixel_data, pat(1023));
        check("wr_no_early_frame", frame_cnt, 0);
        set_pix(10'd0);
        tick();
        check("wr_frame_pulse", bus.frame_start, 1);
        tick();
        check("wr_frame_drop", bus.frame_start, 0);
        repeat (5) tick();
        check("wr_frame_count", frame_cnt, 1);
        check("wr_px_0", bus.pixel_data, pat(0));

        run_clear(1'b1);
        check("clr_pixel_zero", bus.pixel_data, 0);
        check("clr_frame_count", frame_cnt, 1);

        // Reset while the clear pointer sits at 300.
        set_pix(10'd0);
        repeat (6) tick();
        bus.clr_start = 1'b1;
        for (int i = 0; i < 300; i++) wr_q.push_back({10'(i), FB_CLR_BYTE});
        tick();
        bus.clr_start = 1'b0;
        repeat (300) tick();
        check("rmc_last_addr", bus.ram_addr, 299);
        check("rmc_busy_before", bus.clr_busy, 1);
        rst_btn = 1'b1;
        tick();
        check("rmc_busy_after", bus.clr_busy, 0);
        check("rmc_ram_en", bus.ram_en, 0);
        log_q.delete();
        rd_q.push_back(10'd0);
        rst_btn = 1'b0;
        repeat (10) tick();
        nw = 0;
        foreach (log_q[k]) if (log_q[k][10]) nw++;
        check("rmc_no_writes", nw, 0);
        check("rmc_wr_left", wr_q.size(), 0);
        check("rmc_rd_left", rd_q.size(), 0);
        check("rmc_pixel", bus.pixel_data, 0);

        run_clear(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
